// File: rtl/counter_sequencer_if.sv
// rtl/counter_sequencer_if.sv - button inputs and counter outputs of counter_sequencer
interface counter_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             btn_run;
  logic             btn_mode;
  logic             btn_clr;
  logic [WIDTH-1:0] count;
  logic             running;
  logic [1:0]       mode;
  logic             step;

  modport master (
    output btn_run, btn_mode, btn_clr,
    input  count, running, mode, step
  );

  modport slave (
    input  btn_run, btn_mode, btn_clr,
    output count, running, mode, step
  );
endinterface

// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - debounced run/mode/clear controller driving a stepped pin counter
module counter_sequencer #(
  parameter int CLK_HZ          = 16_000_000,
  parameter int STEP_HZ         = 1,
  parameter int DEBOUNCE_CYCLES = 160_000,
  parameter int WIDTH           = 4
) (
  input logic                clk,
  input logic                rst_n,
  counter_sequencer_if.slave bus
);
  localparam int DIV = CLK_HZ / STEP_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);
  localparam logic [DBW-1:0]   DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] COUNT_MAX  = '1;
  localparam int BTN_RUN  = 0;
  localparam int BTN_MODE = 1;
  localparam int BTN_CLR  = 2;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  typedef enum logic [1:0] {MODE_UP = 2'd0, MODE_DOWN = 2'd1, MODE_BOUNCE = 2'd2} mode_t;

  logic [2:0]     raw;
  logic [2:0]     sync1;
  logic [2:0]     sync2;
  logic [2:0]     level;
  logic [2:0]     press;
  logic [DBW-1:0] db_cnt [3];

  state_t           state_q, state_next;
  mode_t            mode_q, mode_next;
  logic [PW-1:0]    presc_q;
  logic [WIDTH-1:0] count_q, count_step;
  logic             dir_up, dir_step;
  logic             step_q;
  logic             run_press, mode_press, clr_press;
  logic             wrap, enter_run;

  assign raw = {bus.btn_clr, bus.btn_mode, bus.btn_run};

  // A level is accepted only after DEBOUNCE_CYCLES straight cycles of disagreement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      press <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] != level[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            level[i]  <= sync2[i];
            db_cnt[i] <= '0;
            press[i]  <= sync2[i];
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign run_press  = press[BTN_RUN];
  assign mode_press = press[BTN_MODE];
  assign clr_press  = press[BTN_CLR];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    if (clr_press) begin
      state_next = IDLE;
    end else if (run_press) begin
      case (state_q)
        IDLE:    state_next = RUN;
        RUN:     state_next = PAUSE;
        PAUSE:   state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  assign wrap      = (state_q == RUN) && (presc_q == PRESC_LAST);
  assign enter_run = (state_next == RUN) && (state_q != RUN);

  always_comb begin
    count_step = count_q;
    dir_step   = dir_up;
    case (mode_q)
      MODE_UP:   count_step = count_q + 1'b1;
      MODE_DOWN: count_step = count_q - 1'b1;
      default: begin
        if (dir_up) begin
          if (count_q == COUNT_MAX) begin
            count_step = COUNT_MAX - 1'b1;
            dir_step   = 1'b0;
          end else begin
            count_step = count_q + 1'b1;
          end
        end else begin
          if (count_q == '0) begin
            count_step = WIDTH'(1);
            dir_step   = 1'b1;
          end else begin
            count_step = count_q - 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    mode_next = mode_q;
    case (mode_q)
      MODE_UP:   mode_next = MODE_DOWN;
      MODE_DOWN: mode_next = MODE_BOUNCE;
      default:   mode_next = MODE_UP;
    endcase
  end

  // The mode update comes last so entering BOUNCE overrides a same-cycle direction change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      presc_q <= '0;
      mode_q  <= MODE_UP;
      dir_up  <= 1'b1;
      step_q  <= 1'b0;
    end else begin
      step_q <= wrap && !clr_press;
      if (clr_press) begin
        count_q <= '0;
        presc_q <= '0;
        dir_up  <= 1'b1;
      end else begin
        if (wrap) begin
          count_q <= count_step;
          dir_up  <= dir_step;
        end
        if (enter_run)             presc_q <= '0;
        else if (state_q == RUN)   presc_q <= wrap ? '0 : presc_q + 1'b1;
      end
      if (mode_press) begin
        mode_q <= mode_next;
        if (mode_next == MODE_BOUNCE) dir_up <= 1'b1;
      end
    end
  end

  assign bus.count   = count_q;
  assign bus.running = (state_q == RUN);
  assign bus.mode    = mode_q;
  assign bus.step    = step_q;
endmodule

// File: tb/tb_counter_sequencer.sv
// tb/tb_counter_sequencer.sv - self-checking bench for counter_sequencer against a step-sequence model
module tb_counter_sequencer;
  localparam int CLK_HZ = 10;
  localparam int STEP_HZ = 1;
  localparam int DEB = 4;
  localparam int WIDTH = 4;
  localparam int DIV = CLK_HZ / STEP_HZ;
  localparam int MAXV = (1 << WIDTH) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  counter_sequencer_if #(.WIDTH(WIDTH)) bus ();

  counter_sequencer #(
    .CLK_HZ(CLK_HZ), .STEP_HZ(STEP_HZ), .DEBOUNCE_CYCLES(DEB), .WIDTH(WIDTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int rise_t = 0;
  logic prev_run = 1'b0;
  int obs_q[$];
  int obs_t[$];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.step === 1'b1) begin
      obs_q.push_back(int'(bus.count));
      obs_t.push_back(cyc);
    end
    if (bus.running === 1'b1 && prev_run !== 1'b1) rise_t = cyc;
    prev_run = bus.running;
  end

  // Reference: bounce walks a triangle of period 2*MAXV indexed by a phase.
  int m_count = 0;
  int m_mode = 0;
  int m_phase = 0;

  function automatic void model_step();
    case (m_mode)
      0: m_count = (m_count + 1) % (MAXV + 1);
      1: m_count = (m_count + MAXV) % (MAXV + 1);
      default: begin
        m_phase = (m_phase + 1) % (2 * MAXV);
        m_count = (m_phase <= MAXV) ? m_phase : 2 * MAXV - m_phase;
      end
    endcase
  endfunction

  function automatic void model_mode_press();
    m_mode = (m_mode + 1) % 3;
    if (m_mode == 2) m_phase = m_count;
  endfunction

  function automatic void model_clear();
    m_count = 0;
    m_phase = 0;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int which, input int hold);
    case (which)
      0: bus.btn_run = 1'b1;
      1: bus.btn_mode = 1'b1;
      default: bus.btn_clr = 1'b1;
    endcase
    idle(hold);
    bus.btn_run = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_clr = 1'b0;
  endtask

  task automatic pop_step(output int val, output int t, output bit ok);
    int n;
    n = 0;
    while (obs_q.size() == 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (obs_q.size() > 0) begin
      val = obs_q.pop_front();
      t = obs_t.pop_front();
      ok = 1'b1;
    end else begin
      val = -1;
      t = 0;
      ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    checks++; if (bus.count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL reset_running: got %0b expected 0", bus.running); end
    checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d expected 0", bus.mode); end
    checks++; if (bus.step !== 1'b0) begin errors++; $display("FAIL reset_step: got %0b expected 0", bus.step); end
    rst_n = 1'b1;
    idle(5);
    checks++; if (bus.running !== 1'b0 || obs_q.size() != 0) begin errors++; $display("FAIL post_reset_idle: running=%0b steps=%0d expected 0 0", bus.running, obs_q.size()); end
  endtask

  task automatic test_start();
    int lat, v, t, pt;
    bit ok;
    obs_q.delete();
    obs_t.delete();
    bus.btn_run = 1'b1;
    lat = 0;
    while (bus.running !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat < DEB + 2 || lat > DEB + 4) begin errors++; $display("FAIL run_latency: got %0d cycles expected 6..8", lat); end
    idle(4);
    bus.btn_run = 1'b0;
    model_step();
    pop_step(v, t, ok);
    checks++; if (!ok || v !== m_count) begin errors++; $display("FAIL first_step_value: got %0d expected %0d", v, m_count); end
    checks++; if (t - rise_t !== DIV) begin errors++; $display("FAIL first_step_delay: got %0d expected %0d", t - rise_t, DIV); end
    for (int i = 0; i < 15; i++) begin
      pt = t;
      model_step();
      pop_step(v, t, ok);
      checks++; if (!ok || v !== m_count) begin errors++; $display("FAIL up_step%0d: got %0d expected %0d", i, v, m_count); end
      checks++; if (t - pt !== DIV) begin errors++; $display("FAIL up_interval%0d: got %0d expected %0d", i, t - pt, DIV); end
    end
    checks++; if (v !== 0) begin errors++; $display("FAIL up_wrap: got %0d expected 0", v); end
  endtask

  task automatic test_down();
    int v, t;
    bit ok;
    for (int i = 0; i < 16 && m_count != 3; i++) begin
      model_step();
      pop_step(v, t, ok);
      checks++; if (!ok || v !== m_count) begin errors++; $display("FAIL pre_down_step%0d: got %0d expected %0d", i, v, m_count); end
    end
    press(1, 10);
    model_mode_press();
    checks++; if (int'(bus.mode) !== m_mode) begin errors++; $display("FAIL down_mode: got %0d expected %0d", bus.mode, m_mode); end
    for (int i = 0; i < 5; i++) begin
      model_step();
      pop_step(v, t, ok);
      checks++; if (!ok || v !== m_count) begin errors++; $display("FAIL down_step%0d: got %0d expected %0d", i, v, m_count); end
    end
    checks++; if (v !== 14) begin errors++; $display("FAIL down_end: got %0d expected 14", v); end
  endtask

  task automatic test_bounce();
    int v, t;
    bit ok;
    press(0, 10);
    idle(10);
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL bounce_pause: running=%0b expected 0", bus.running); end
    for (int k = 0; k < 4; k++) begin
      press(1, 8);
      idle(8);
      model_mode_press();
      checks++; if (int'(bus.mode) !== m_mode) begin errors++; $display("FAIL mode_cycle%0d: got %0d expected %0d", k, bus.mode, m_mode); end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL paused_steps: got %0d expected 0", obs_q.size()); end
    press(0, 10);
    model_step();
    pop_step(v, t, ok);
    checks++; if (!ok || v !== m_count) begin errors++; $display("FAIL bounce_first: got %0d expected %0d", v, m_count); end
    checks++; if (t - rise_t !== DIV) begin errors++; $display("FAIL bounce_resume_delay: got %0d expected %0d", t - rise_t, DIV); end
    for (int i = 0; i < 17; i++) begin
      model_step();
      pop_step(v, t, ok);
      checks++; if (!ok || v !== m_count) begin errors++; $display("FAIL bounce_step%0d: got %0d expected %0d", i, v, m_count); end
    end
    checks++; if (v !== 2) begin errors++; $display("FAIL bounce_end: got %0d expected 2", v); end
  endtask

  task automatic test_pause();
    int v, t;
    bit ok;
    for (int i = 0; i < 30 && m_count != 5; i++) begin
      model_step();
      pop_step(v, t, ok);
      checks++; if (!ok || v !== m_count) begin errors++; $display("FAIL pre_pause_step%0d: got %0d expected %0d", i, v, m_count); end
    end
    press(0, 10);
    idle(2);
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL pause_running: got %0b expected 0", bus.running); end
    idle(50);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL pause_no_step: got %0d steps expected 0", obs_q.size()); end
    checks++; if (int'(bus.count) !== m_count) begin errors++; $display("FAIL pause_hold: got %0d expected %0d", bus.count, m_count); end
    press(0, 10);
    model_step();
    pop_step(v, t, ok);
    checks++; if (!ok || v !== m_count) begin errors++; $display("FAIL resume_value: got %0d expected %0d", v, m_count); end
    checks++; if (t - rise_t !== DIV) begin errors++; $display("FAIL resume_delay: got %0d expected %0d", t - rise_t, DIV); end
  endtask

  task automatic test_glitch();
    int dropped, h, v, t;
    bit ok;
    dropped = 0;
    for (int g = 0; g < 10; g++) begin
      h = $urandom_range(1, 3);
      bus.btn_run = 1'b1;
      repeat (h) begin
        @(negedge clk);
        if (bus.running !== 1'b1) dropped++;
      end
      bus.btn_run = 1'b0;
      repeat ($urandom_range(3, 6)) begin
        @(negedge clk);
        if (bus.running !== 1'b1) dropped++;
      end
    end
    idle(10);
    checks++; if (dropped != 0 || bus.running !== 1'b1) begin errors++; $display("FAIL glitch_state: dropped=%0d running=%0b expected 0 1", dropped, bus.running); end
    checks++; if (int'(bus.mode) !== m_mode) begin errors++; $display("FAIL glitch_mode: got %0d expected %0d", bus.mode, m_mode); end
    while (obs_q.size() > 0) begin
      model_step();
      pop_step(v, t, ok);
      checks++; if (!ok || v !== m_count) begin errors++; $display("FAIL glitch_step: got %0d expected %0d", v, m_count); end
    end
  endtask

  task automatic test_clear();
    int n, v, t;
    bit ok;
    bus.btn_run = 1'b1;
    bus.btn_clr = 1'b1;
    n = 0;
    while (bus.running === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 20) begin errors++; $display("FAIL clear_timeout: running=%0b after %0d cycles expected 0", bus.running, n); end
    idle(8);
    bus.btn_run = 1'b0;
    bus.btn_clr = 1'b0;
    while (obs_q.size() > 0) begin
      model_step();
      pop_step(v, t, ok);
      checks++; if (!ok || v !== m_count) begin errors++; $display("FAIL pre_clear_step: got %0d expected %0d", v, m_count); end
    end
    model_clear();
    idle(15);
    checks++; if (int'(bus.count) !== m_count) begin errors++; $display("FAIL clear_count: got %0d expected %0d", bus.count, m_count); end
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL clear_running: got %0b expected 0", bus.running); end
    checks++; if (int'(bus.mode) !== m_mode) begin errors++; $display("FAIL clear_mode: got %0d expected %0d", bus.mode, m_mode); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL clear_no_step: got %0d expected 0", obs_q.size()); end
  endtask

  task automatic test_async_reset();
    int v, t;
    bit ok;
    press(0, 10);
    for (int i = 0; i < 30 && m_count != 9; i++) begin
      model_step();
      pop_step(v, t, ok);
      checks++; if (!ok || v !== m_count) begin errors++; $display("FAIL pre_reset_step%0d: got %0d expected %0d", i, v, m_count); end
    end
    idle(3);
    checks++; if (int'(bus.count) !== 9) begin errors++; $display("FAIL pre_reset_count: got %0d expected 9", bus.count); end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.count !== '0) begin errors++; $display("FAIL async_count: got %0d expected 0", bus.count); end
    checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL async_running: got %0b expected 0", bus.running); end
    checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL async_mode: got %0d expected 0", bus.mode); end
    checks++; if (bus.step !== 1'b0) begin errors++; $display("FAIL async_step: got %0b expected 0", bus.step); end
    @(negedge clk);
    rst_n = 1'b1;
    m_mode = 0;
    model_clear();
    obs_q.delete();
    obs_t.delete();
    idle(30);
    checks++; if (bus.running !== 1'b0 || bus.count !== '0 || obs_q.size() != 0) begin
      errors++; $display("FAIL post_async_idle: running=%0b count=%0d steps=%0d expected 0 0 0", bus.running, bus.count, obs_q.size());
    end
  endtask

  initial begin
    bus.btn_run = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_clr = 1'b0;
    test_reset();
    test_start();
    test_down();
    test_bounce();
    test_pause();
    test_glitch();
    test_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Button-driven run/mode controller for the 4-bit pin counter on the 16 MHz board.
- Replaces the free-running divider plus counter pair with a sequenced datapath: start/pause, clear, and up/down/bounce count modes.
- Debounces three raw push-buttons and prescales clk into a step enable.
- Owns the count register that drives the LED pins.

Parameters:
- CLK_HZ, 16_000_000, input clock frequency.
- STEP_HZ, 1, count steps per second; CLK_HZ/STEP_HZ must be an integer >= 2.
- DEBOUNCE_CYCLES, 160_000, number of consecutive stable cycles needed to accept a button level (10 ms at 16 MHz); must be >= 1.
- WIDTH, 4, count width; must be >= 2.

Ports:
- clk  in  1  system clock, 16 MHz.
- rst_n  in  1  asynchronous active-low reset; deassertion is synchronous to clk externally.
- btn_run  in  1  raw run/pause button, active-high, asynchronous.
- btn_mode  in  1  raw mode-cycle button, active-high, asynchronous.
- btn_clr  in  1  raw clear button, active-high, asynchronous.
- count  out  WIDTH  counter value; drives the pins.
- running  out  1  high while in state RUN.
- mode  out  2  0=UP, 1=DOWN, 2=BOUNCE; value 3 is never produced.
- step  out  1  one-cycle pulse, coincident with each new count value.

Behaviour:
- Reset (rst_n low) takes effect immediately and asynchronously, including mid-run:
  - count=0, running=0, mode=UP, step=0.
  - state=IDLE, bounce direction=up.
  - prescaler=0, synchronizers and debounced levels=0.
- Button input path, per button:
  - 2-flop synchronizer.
  - Debounce counter: accepts a new level only after DEBOUNCE_CYCLES consecutive cycles of the synchronized value differing from the accepted level. Any mismatch-free cycle resets the counter.
  - A rising edge of the accepted level produces a one-cycle internal press event.
  - Press latency after a clean raw edge is DEBOUNCE_CYCLES+2..DEBOUNCE_CYCLES+4 cycles.
  - Release generates no event. Bounces shorter than DEBOUNCE_CYCLES generate nothing.
- Prescaler:
  - DIV = CLK_HZ/STEP_HZ. Counts 0..DIV-1 only in RUN. Wrap = prescaler at DIV-1 in RUN.
  - Forced to 0 on every entry to RUN, so the first step occurs exactly DIV cycles after the transition edge.
  - Held (frozen) in PAUSE.
- FSM, states IDLE, RUN, PAUSE:
  - IDLE + run press -> RUN.
  - RUN + run press -> PAUSE.
  - PAUSE + run press -> RUN; count is retained and the prescaler restarts from 0.
  - Any state + clr press -> IDLE with count=0, prescaler=0, direction=up; mode is unchanged.
  - clr has priority over run in the same cycle.
- Mode press, accepted in any state: UP -> DOWN -> BOUNCE -> UP.
  - Entering BOUNCE sets direction=up.
  - The new mode applies from the next step; mode output updates the cycle after the press event.
  - A mode press and a wrap in the same cycle: the wrap uses the old mode.
- Count update happens on the edge where the prescaler wraps; step is high for the following cycle. MAX = 2^WIDTH-1.
  - UP: count+1 modulo 2^WIDTH (MAX -> 0).
  - DOWN: count-1 modulo 2^WIDTH (0 -> MAX).
  - BOUNCE, direction up: if count==MAX then count=MAX-1 and direction=down, else count+1.
  - BOUNCE, direction down: if count==0 then count=1 and direction=up, else count-1.
  - Each endpoint is shown for exactly one step.
- Simultaneous events:
  - clr press with a wrap: clear wins, no step pulse.
  - run press (RUN -> PAUSE) with a wrap: the wrap's count update and step complete, then the state pauses.
- Outputs are all registered; no combinational path from the button inputs.

Test Plan:
- Bench parameters: CLK_HZ=10, STEP_HZ=1 (DIV=10), DEBOUNCE_CYCLES=4, WIDTH=4.
- Reset, then a clean btn_run press:
  - running rises within 6..8 cycles.
  - First step occurs 10 cycles after running rises, with count=1.
  - 15 further steps bring count to 0 (wrap).
- Press btn_mode once while running at count=3 -> mode=1. Subsequent steps give 2, 1, 0, 15, 14.
- Press btn_mode twice from UP (mode=2), with count at 14 -> steps give 15, 14, 13. Later from count 1 -> 0, 1, 2.
- Pause at count=5 via btn_run -> count stays 5 and no step for 50 cycles. Resume -> next step comes exactly 10 cycles after running rises, with count=6.
- btn_run glitches of 1..3 cycles, 10 times -> no state change. btn_clr pressed together with btn_run while running -> IDLE, count=0, running=0.
- Assert rst_n low mid-run at count=9, asynchronously between clock edges -> all outputs reach reset values before the next edge. After release the state stays IDLE.
